// File: rtl/debounce_pkg.sv
// Shared types and helpers for the switch debounce/event scheduler.
// Holds the event record and the channel-index width calculation.
package debounce_pkg;

    localparam int MAX_CH_W = 4;

    typedef struct packed {
        logic [MAX_CH_W-1:0] ch;
        logic                rise;
    } ev_t;

    // Index width for n channels; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts one past ptr_i and wraps, so the last winner has the lowest priority.
module rr_arbiter
    import debounce_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         grant_valid_o,
    output logic [W-1:0] grant_idx_o
);

    logic [W-1:0] cand_s;
    logic         hit_s;

    // First requester found walking forward from ptr_i+1 wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = {W{1'b0}};
        cand_s        = {W{1'b0}};
        hit_s         = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand_s        = W'((int'(ptr_i) + k) % N);
            hit_s         = !grant_valid_o && req_i[cand_s];
            grant_idx_o   = hit_s ? cand_s : grant_idx_o;
            grant_valid_o = grant_valid_o | hit_s;
        end
    end

endmodule

// File: rtl/debounce_scheduler.sv
// Multi-channel switch debouncer with a shared sample prescaler.
// Committed edges are serialised round-robin onto one valid/ready event port.
module debounce_scheduler
    import debounce_pkg::*;
#(
    parameter  int N_CH    = 4,
    parameter  int PRESC_W = 20,
    parameter  int STABLE  = 3,
    localparam int CH_W    = idx_width(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] sw,
    output logic [N_CH-1:0] db_level,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [CH_W-1:0] ev_ch,
    output logic            ev_rise,
    output logic [N_CH-1:0] ovr_err,
    input  logic            clr_err
);

    localparam int CNT_W = $clog2(STABLE + 1);

    logic [N_CH-1:0]            sync1_q, sync2_q;
    logic [PRESC_W-1:0]         presc_q, presc_d;
    logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]            db_q, db_d;
    logic [N_CH-1:0]            pend_q, pend_d;
    logic [N_CH-1:0]            dir_q, dir_d;
    logic [N_CH-1:0]            ovr_q, ovr_d;
    logic [CH_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic                       ev_valid_q, ev_valid_d;
    ev_t                        ev_q, ev_d;

    logic                       tick_s, load_s, grant_valid_s;
    logic [CH_W-1:0]            grant_idx_s;
    logic [N_CH-1:0]            commit_s, grant_clr_s, ovr_set_s;
    logic                       unused_ev_bits_s;

    rr_arbiter #(.N(N_CH)) u_arb (
        .req_i         (pend_q),
        .ptr_i         (rr_ptr_q),
        .grant_valid_o (grant_valid_s),
        .grant_idx_o   (grant_idx_s)
    );

    // Next-state logic: sampling, stability counting, pending/overrun and output register.
    always_comb begin
        tick_s   = &presc_q;
        load_s   = !ev_valid_q || ev_ready;
        presc_d  = presc_q + PRESC_W'(1);
        cnt_d    = cnt_q;
        db_d     = db_q;
        commit_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            if (!tick_s) begin
                cnt_d[i] = cnt_q[i];
            end else if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = {CNT_W{1'b0}};
            end else if (cnt_q[i] == CNT_W'(STABLE - 1)) begin
                cnt_d[i]    = {CNT_W{1'b0}};
                db_d[i]     = ~db_q[i];
                commit_s[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        // A commit on the channel being granted re-arms pend rather than overrunning.
        grant_clr_s = (load_s && grant_valid_s) ?
                      ({{(N_CH-1){1'b0}}, 1'b1} << grant_idx_s) : {N_CH{1'b0}};
        pend_d    = commit_s | (pend_q & ~grant_clr_s);
        dir_d     = (commit_s & db_d) | (~commit_s & dir_q);
        ovr_set_s = commit_s & pend_q & ~grant_clr_s;
        ovr_d     = (clr_err ? {N_CH{1'b0}} : ovr_q) | ovr_set_s;

        ev_valid_d = ev_valid_q;
        ev_d       = ev_q;
        rr_ptr_d   = rr_ptr_q;
        if (load_s) begin
            ev_valid_d = grant_valid_s;
            if (grant_valid_s) begin
                ev_d.ch   = MAX_CH_W'(grant_idx_s);
                ev_d.rise = dir_q[grant_idx_s];
                rr_ptr_d  = grant_idx_s;
            end else begin
                ev_d     = ev_q;
                rr_ptr_d = rr_ptr_q;
            end
        end else begin
            ev_valid_d = ev_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= {N_CH{1'b0}};
            sync2_q    <= {N_CH{1'b0}};
            presc_q    <= {PRESC_W{1'b0}};
            cnt_q      <= {(N_CH*CNT_W){1'b0}};
            db_q       <= {N_CH{1'b0}};
            pend_q     <= {N_CH{1'b0}};
            dir_q      <= {N_CH{1'b0}};
            ovr_q      <= {N_CH{1'b0}};
            rr_ptr_q   <= {CH_W{1'b0}};
            ev_valid_q <= 1'b0;
            ev_q.ch    <= {MAX_CH_W{1'b0}};
            ev_q.rise  <= 1'b0;
        end else begin
            sync1_q    <= sw;
            sync2_q    <= sync1_q;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            db_q       <= db_d;
            pend_q     <= pend_d;
            dir_q      <= dir_d;
            ovr_q      <= ovr_d;
            rr_ptr_q   <= rr_ptr_d;
            ev_valid_q <= ev_valid_d;
            ev_q       <= ev_d;
        end
    end

    assign unused_ev_bits_s = ^ev_q.ch;
    assign db_level = db_q;
    assign ev_valid = ev_valid_q;
    assign ev_ch    = ev_q.ch[CH_W-1:0];
    assign ev_rise  = ev_q.rise;
    assign ovr_err  = ovr_q;

endmodule
